// File: rtl/taillight_pkg.sv
// Shared types and lamp constants for the tail-light sequencer.
// Also holds the helpers that map a request or a state onto a mode.
package taillight_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_L1   = 4'd1,
        ST_L2   = 4'd2,
        ST_L3   = 4'd3,
        ST_LOFF = 4'd4,
        ST_R1   = 4'd5,
        ST_R2   = 4'd6,
        ST_R3   = 4'd7,
        ST_ROFF = 4'd8,
        ST_HON  = 4'd9,
        ST_HOFF = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    // Side patterns: left side is {LC,LB,LA}, right side is {RA,RB,RC}
    localparam logic [2:0] SIDE_OFF = 3'b000;
    localparam logic [2:0] SIDE_ALL = 3'b111;
    localparam logic [2:0] LEFT_P1  = 3'b001;
    localparam logic [2:0] LEFT_P2  = 3'b011;
    localparam logic [2:0] RIGHT_P1 = 3'b100;
    localparam logic [2:0] RIGHT_P2 = 3'b110;

    function automatic mode_t decode_req(logic left_s, logic right_s, logic hazard_s);
        if (hazard_s || (left_s && right_s)) return MODE_HAZ;
        else if (left_s)                     return MODE_LEFT;
        else if (right_s)                    return MODE_RIGHT;
        else                                 return MODE_IDLE;
    endfunction

    function automatic mode_t state_mode(state_t s);
        case (s)
            ST_L1, ST_L2, ST_L3, ST_LOFF: return MODE_LEFT;
            ST_R1, ST_R2, ST_R3, ST_ROFF: return MODE_RIGHT;
            ST_HON, ST_HOFF:              return MODE_HAZ;
            default:                      return MODE_IDLE;
        endcase
    endfunction

    // Successor within the current sequence; anything else falls back to idle
    function automatic state_t advance(state_t s);
        case (s)
            ST_L1:   return ST_L2;
            ST_L2:   return ST_L3;
            ST_L3:   return ST_LOFF;
            ST_LOFF: return ST_L1;
            ST_R1:   return ST_R2;
            ST_R2:   return ST_R3;
            ST_R3:   return ST_ROFF;
            ST_ROFF: return ST_R1;
            ST_HON:  return ST_HOFF;
            ST_HOFF: return ST_HON;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/input_sync.sv
// Two-stage synchronizer for the four asynchronous request inputs.
module input_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tail_sequencer.sv
// Tail-light sequencer: synchronized requests drive a stepped left/right/hazard
// lamp FSM whose pattern and mode outputs are registered from the next state.
module tail_sequencer #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       brake,
    input  logic       hazard,
    output logic [5:0] pattern,
    output logic [1:0] mode,
    output logic       step
);

    import taillight_pkg::*;

    localparam int                 CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [3:0]       sync_q;
    logic             left_s;
    logic             right_s;
    logic             brake_s;
    logic             hazard_s;
    mode_t            req;
    mode_t            cur_mode;
    mode_t            mode_next;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [5:0]       pattern_next;

    input_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({hazard, brake, right, left}),
        .q   (sync_q)
    );

    assign left_s   = sync_q[0];
    assign right_s  = sync_q[1];
    assign brake_s  = sync_q[2];
    assign hazard_s = sync_q[3];

    assign req      = decode_req(left_s, right_s, hazard_s);
    assign cur_mode = state_mode(state);
    assign tick     = (state != ST_IDLE) && (cnt == CNT_MAX);

    // State register; outputs are loaded alongside so they track the new state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            step    <= 1'b0;
            pattern <= '0;
            mode    <= MODE_IDLE;
        end else begin
            state   <= state_next;
            cnt     <= (state == ST_IDLE || tick) ? '0 : cnt + CNT_W'(1);
            step    <= tick;
            pattern <= pattern_next;
            mode    <= mode_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                case (req)
                    MODE_LEFT:  state_next = ST_L1;
                    MODE_RIGHT: state_next = ST_R1;
                    MODE_HAZ:   state_next = ST_HON;
                    default:    state_next = ST_IDLE;
                endcase
            end
            ST_L1, ST_L2, ST_L3, ST_LOFF,
            ST_R1, ST_R2, ST_R3, ST_ROFF,
            ST_HON, ST_HOFF: begin
                if (tick) begin
                    if (req == cur_mode)     state_next = advance(state);
                    else if (req == MODE_HAZ) state_next = ST_HON;
                    else                     state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The side not being sequenced follows brake; hazard overrides both sides
    always_comb begin
        mode_next    = state_mode(state_next);
        pattern_next = brake_s ? {SIDE_ALL, SIDE_ALL} : {SIDE_OFF, SIDE_OFF};
        case (state_next)
            ST_L1:   pattern_next[5:3] = LEFT_P1;
            ST_L2:   pattern_next[5:3] = LEFT_P2;
            ST_L3:   pattern_next[5:3] = SIDE_ALL;
            ST_LOFF: pattern_next[5:3] = SIDE_OFF;
            ST_R1:   pattern_next[2:0] = RIGHT_P1;
            ST_R2:   pattern_next[2:0] = RIGHT_P2;
            ST_R3:   pattern_next[2:0] = SIDE_ALL;
            ST_ROFF: pattern_next[2:0] = SIDE_OFF;
            ST_HON:  pattern_next      = {SIDE_ALL, SIDE_ALL};
            ST_HOFF: pattern_next      = {SIDE_OFF, SIDE_OFF};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tail_sequencer.sv
// Bench for tail_sequencer with TICK_DIV=4: cycle-by-cycle model comparison
// plus directed scenarios with hand-computed lamp patterns.
module tb_tail_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       brake = 1'b0;
    logic       hazard = 1'b0;
    logic [5:0] pattern;
    logic [1:0] mode;
    logic       step;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    tail_sequencer #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst     (rst),
        .left    (left),
        .right   (right),
        .brake   (brake),
        .hazard  (hazard),
        .pattern (pattern),
        .mode    (mode),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: requests delayed two cycles, then a mode plus a
    // position index into per-mode lamp tables, advanced every TD cycles.
    logic [2:0] left_seq  [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [2:0] right_seq [4] = '{3'b100, 3'b110, 3'b111, 3'b000};
    logic [3:0] s1 = '0, s2 = '0;
    int         m_mode = 0, m_idx = 0, m_cnt = 0;
    logic [5:0] e_pat = '0;
    logic [1:0] e_mode = '0;
    logic       e_step = 1'b0;

    always @(posedge clk) begin
        int  req;
        int  len;
        logic brk;
        if (rst) begin
            s1 = '0; s2 = '0;
            m_mode = 0; m_idx = 0; m_cnt = 0;
            e_pat = '0; e_mode = '0; e_step = 1'b0;
        end else begin
            if (s2[3] || (s2[0] && s2[1])) req = 3;
            else if (s2[0])                req = 1;
            else if (s2[1])                req = 2;
            else                           req = 0;
            brk    = s2[2];
            e_step = 1'b0;
            if (m_mode == 0) begin
                m_cnt = 0;
                if (req != 0) begin
                    m_mode = req;
                    m_idx  = 0;
                end
            end else if (m_cnt == TD - 1) begin
                e_step = 1'b1;
                m_cnt  = 0;
                len    = (m_mode == 3) ? 2 : 4;
                if (req == m_mode) m_idx = (m_idx + 1) % len;
                else if (req == 3) begin m_mode = 3; m_idx = 0; end
                else               begin m_mode = 0; m_idx = 0; end
            end else begin
                m_cnt++;
            end
            e_mode = m_mode[1:0];
            case (m_mode)
                1:       e_pat = {left_seq[m_idx], brk ? 3'b111 : 3'b000};
                2:       e_pat = {brk ? 3'b111 : 3'b000, right_seq[m_idx]};
                3:       e_pat = (m_idx == 0) ? 6'b111111 : 6'b000000;
                default: e_pat = brk ? 6'b111111 : 6'b000000;
            endcase
            s2 = s1;
            s1 = {hazard, brake, right, left};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pattern", pattern, e_pat);
            chk("cyc_mode", {4'b0, mode}, {4'b0, e_mode});
            chk("cyc_step", {5'b0, step}, {5'b0, e_step});
        end
    end

    // Advance n rising edges and settle a few ns after the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        left = 0; right = 0; brake = 0; hazard = 0;
        rst = 1;
        edges(1);
        chk("rst_pattern", pattern, 6'b000000);
        chk("rst_mode", {4'b0, mode}, 6'd0);
        chk("rst_step", {5'b0, step}, 6'd0);
        rst = 0;
    endtask

    initial begin
        edges(2);
        chk_en = 1'b1;
        do_reset();

        // Left sequence from idle
        left = 1;
        edges(2); chk("l_pre", pattern, 6'b000000);
        edges(1); chk("l1", pattern, 6'b001000);
        chk("l1_mode", {4'b0, mode}, 6'd1);
        edges(4); chk("l2", pattern, 6'b011000);
        chk("l2_step", {5'b0, step}, 6'd1);
        edges(1); chk("l2_step_low", {5'b0, step}, 6'd0);
        edges(3); chk("l3", pattern, 6'b111000);
        edges(4); chk("loff", pattern, 6'b000000);
        edges(4); chk("l1_wrap", pattern, 6'b001000);

        // Right sequence with brake, then brake release
        do_reset();
        right = 1; brake = 1;
        edges(3); chk("rb1", pattern, 6'b111100);
        edges(4); chk("rb2", pattern, 6'b111110);
        edges(4); chk("rb3", pattern, 6'b111111);
        edges(4); chk("rboff", pattern, 6'b111000);
        chk("rb_mode", {4'b0, mode}, 6'd2);
        brake = 0;
        edges(2); chk("rb_brake_hold", pattern, 6'b111000);
        edges(1); chk("rb_brake_drop", pattern, 6'b000000);

        // Left and right together act as hazard
        do_reset();
        left = 1; right = 1;
        edges(3); chk("lr_hon", pattern, 6'b111111);
        chk("lr_mode", {4'b0, mode}, 6'd3);
        edges(3); chk("lr_step_low", {5'b0, step}, 6'd0);
        edges(1); chk("lr_hoff", pattern, 6'b000000);
        chk("lr_step", {5'b0, step}, 6'd1);
        edges(4); chk("lr_hon2", pattern, 6'b111111);

        // Hazard requested during L2
        do_reset();
        left = 1;
        edges(7); chk("hz_l2", pattern, 6'b011000);
        hazard = 1;
        edges(3); chk("hz_wait", pattern, 6'b011000);
        edges(1); chk("hz_hon", pattern, 6'b111111);
        chk("hz_mode", {4'b0, mode}, 6'd3);

        // Left dropped during L2, then brake while idle
        do_reset();
        left = 1;
        edges(7);
        left = 0;
        edges(3); chk("ld_wait", pattern, 6'b011000);
        edges(1); chk("ld_idle", pattern, 6'b000000);
        chk("ld_mode", {4'b0, mode}, 6'd0);
        brake = 1;
        edges(2); chk("ld_brake_wait", pattern, 6'b000000);
        edges(1); chk("ld_brake", pattern, 6'b111111);
        chk("ld_brake_mode", {4'b0, mode}, 6'd0);

        // Reset pulse during R3 with right held
        do_reset();
        right = 1;
        edges(11); chk("rr_r3", pattern, 6'b000111);
        rst = 1;
        edges(1); chk("rr_rst", pattern, 6'b000000);
        chk("rr_rst_mode", {4'b0, mode}, 6'd0);
        rst = 0;
        edges(2); chk("rr_wait", pattern, 6'b000000);
        edges(1); chk("rr_r1", pattern, 6'b000100);
        chk("rr_r1_mode", {4'b0, mode}, 6'd2);

        // One-cycle left pulse: one L1 step, then back to idle
        do_reset();
        left = 1;
        edges(1);
        left = 0;
        edges(2); chk("gl_l1", pattern, 6'b001000);
        edges(4); chk("gl_idle", pattern, 6'b000000);
        chk("gl_mode", {4'b0, mode}, 6'd0);
        edges(4);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
